// File: rtl/loader_pkg.sv
// ============================================================================
// Module   : loader_pkg
// Brief    : Shared state encoding, fault codes and header field order for the UART boot loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_FAIL
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_LEN     = 2'd3
    } err_t;

    // Header bytes arrive in this order, followed by the payload and one checksum byte.
    typedef enum logic [1:0] {
        FLD_ADDR_LO,
        FLD_ADDR_HI,
        FLD_LEN_LO,
        FLD_LEN_HI
    } hdr_field_t;

    function automatic logic is_active(input state_t s);
        return !(s inside {ST_IDLE, ST_DONE, ST_FAIL});
    endfunction

endpackage

`default_nettype wire

// File: rtl/idle_timer.sv
// ============================================================================
// Module   : idle_timer
// Brief    : Counts idle cycles between strobes; expired holds once TIMEOUT_CLKS-1 is reached.
// Revision : 1.0
// ============================================================================
`default_nettype none

module idle_timer #(
    parameter int TIMEOUT_CLKS = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT_CLKS - 1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + c_W'(1);
        end
    end

    assign expired = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_boot_loader.sv
// ============================================================================
// Module   : uart_boot_loader
// Brief    : Receives an addressed, length-prefixed, checksummed frame and writes it to RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_boot_loader
    import loader_pkg::*;
#(
    parameter int          TIMEOUT_CLKS = 5000000,
    parameter logic [15:0] MAX_LEN      = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_strobe,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    state_t      r_state, w_state_n;
    logic [15:0] r_addr, w_addr_n;
    logic [15:0] r_count, w_count_n;
    logic [7:0]  r_sum, w_sum_n;
    logic [15:0] r_mem_addr, w_mem_addr_n;
    logic [7:0]  r_mem_wdata, w_mem_wdata_n;
    logic        r_mem_we, w_mem_we_n;
    logic        r_done, w_done_n;
    logic        r_error, w_error_n;
    err_t        r_err_code, w_err_code_n;
    logic        w_active;
    logic        w_expired;
    logic [7:0]  w_sum_acc;
    logic [15:0] w_len;

    assign w_active  = is_active(r_state);
    assign w_sum_acc = r_sum + rx_data;
    // len_lo is parked in the low byte of the count register until len_hi arrives
    assign w_len     = {rx_data, r_count[7:0]};

    idle_timer #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_strobe || !w_active),
        .enable  (w_active),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_count     <= '0;
            r_sum       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_state     <= w_state_n;
            r_addr      <= w_addr_n;
            r_count     <= w_count_n;
            r_sum       <= w_sum_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_wdata <= w_mem_wdata_n;
            r_mem_we    <= w_mem_we_n;
            r_done      <= w_done_n;
            r_error     <= w_error_n;
            r_err_code  <= w_err_code_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_addr_n      = r_addr;
        w_count_n     = r_count;
        w_sum_n       = r_sum;
        w_mem_addr_n  = r_mem_addr;
        w_mem_wdata_n = r_mem_wdata;
        w_mem_we_n    = 1'b0;
        w_done_n      = r_done;
        w_error_n     = r_error;
        w_err_code_n  = r_err_code;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_n    = ST_ADDR_LO;
                    w_addr_n     = '0;
                    w_count_n    = '0;
                    w_sum_n      = '0;
                    w_done_n     = 1'b0;
                    w_error_n    = 1'b0;
                    w_err_code_n = ERR_NONE;
                end
            end
            ST_ADDR_LO: if (rx_strobe) begin
                w_addr_n  = {r_addr[15:8], rx_data};
                w_sum_n   = w_sum_acc;
                w_state_n = ST_ADDR_HI;
            end
            ST_ADDR_HI: if (rx_strobe) begin
                w_addr_n  = {rx_data, r_addr[7:0]};
                w_sum_n   = w_sum_acc;
                w_state_n = ST_LEN_LO;
            end
            ST_LEN_LO: if (rx_strobe) begin
                w_count_n = {8'h00, rx_data};
                w_sum_n   = w_sum_acc;
                w_state_n = ST_LEN_HI;
            end
            ST_LEN_HI: if (rx_strobe) begin
                w_count_n = w_len;
                w_sum_n   = w_sum_acc;
                if ({1'b0, w_len} > {1'b0, MAX_LEN}) begin
                    w_state_n    = ST_FAIL;
                    w_error_n    = 1'b1;
                    w_err_code_n = ERR_LEN;
                end else if (w_len == 16'd0) begin
                    w_state_n = ST_CSUM;
                end else begin
                    w_state_n = ST_DATA;
                end
            end
            ST_DATA: if (rx_strobe) begin
                w_mem_we_n    = 1'b1;
                w_mem_addr_n  = r_addr;
                w_mem_wdata_n = rx_data;
                w_addr_n      = r_addr + 16'd1;
                w_count_n     = r_count - 16'd1;
                w_sum_n       = w_sum_acc;
                if (r_count == 16'd1) begin
                    w_state_n = ST_CSUM;
                end
            end
            ST_CSUM: if (rx_strobe) begin
                if (rx_data == r_sum) begin
                    w_state_n = ST_DONE;
                    w_done_n  = 1'b1;
                end else begin
                    w_state_n    = ST_FAIL;
                    w_error_n    = 1'b1;
                    w_err_code_n = ERR_CSUM;
                end
            end
            ST_DONE, ST_FAIL: begin
                if (!start) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        // A strobe in the same cycle as expiry takes precedence over the timeout.
        if (w_active && !rx_strobe && w_expired) begin
            w_state_n    = ST_FAIL;
            w_done_n     = 1'b0;
            w_error_n    = 1'b1;
            w_err_code_n = ERR_TIMEOUT;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign cpu_hold  = w_active;
    assign done      = r_done;
    assign error     = r_error;
    assign err_code  = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
// ============================================================================
// Module   : tb_uart_boot_loader
// Brief    : Scoreboard bench for uart_boot_loader: writes and session results checked by a monitor.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_boot_loader;

    localparam int TO = 100;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        start     = 1'b0;
    logic [7:0]  rx_data   = 8'h00;
    logic        rx_strobe = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .TIMEOUT_CLKS (TO),
        .MAX_LEN      (16'h0100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [7:0]  data;
        bit          ok;
        logic [1:0]  code;
        int          cyc;
    } exp_t;

    typedef logic [7:0] bq_t[$];

    exp_t sb[$];
    exp_t m_e;
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   cyc        = 0;
    int   last_strobe = 0;
    logic prev_done  = 1'b0;
    logic prev_error = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic void exp_wr(input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.is_wr = 1'b1; e.addr = a; e.data = d; e.ok = 1'b0; e.code = 2'd0; e.cyc = -1;
        sb.push_back(e);
    endfunction

    function automatic void exp_res(input bit ok, input logic [1:0] code, input int c);
        exp_t e;
        e.is_wr = 1'b0; e.addr = '0; e.data = '0; e.ok = ok; e.code = code; e.cyc = c;
        sb.push_back(e);
    endfunction

    // Monitor: every write pulse and every rising done/error is matched against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (sb.size() == 0 || !sb[0].is_wr) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", mem_addr, mem_wdata);
                end else begin
                    m_e = sb.pop_front();
                    check("wr_addr", {16'h0, mem_addr}, {16'h0, m_e.addr});
                    check("wr_data", {24'h0, mem_wdata}, {24'h0, m_e.data});
                end
            end
            if ((done && !prev_done) || (error && !prev_error)) begin
                if (sb.size() == 0 || sb[0].is_wr) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result: got done %0b error %0b code %0d, required no result yet", done, error, err_code);
                end else begin
                    m_e = sb.pop_front();
                    check("res_done",  {31'h0, done},  {31'h0, m_e.ok});
                    check("res_error", {31'h0, error}, {31'h0, !m_e.ok});
                    check("res_code",  {30'h0, err_code}, {30'h0, m_e.code});
                    check("res_hold",  {31'h0, cpu_hold}, 32'h0);
                    if (m_e.cyc >= 0) check("res_cycle", cyc, m_e.cyc);
                end
            end
        end
        prev_done  = done;
        prev_error = error;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hold_on_start", {31'h0, cpu_hold}, 32'h1);
        check("flags_cleared", {30'h0, done, error}, 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data   = b;
        rx_strobe = 1'b1;
        tick();
        last_strobe = cyc;
        rx_strobe = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_frame(input bq_t q);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d expectations pending after %0d cycles, required 0", sb.size(), budget);
            sb.delete();
        end
        tick();
    endtask

    task automatic check_zero_outputs(input string name);
        check(name, {2'b00, mem_addr, mem_wdata, mem_we, cpu_hold, done, error, err_code}, 32'h0);
    endtask

    initial begin
        bq_t f;
        repeat (3) tick();
        check_zero_outputs("reset_outputs");
        rst = 1'b0;
        tick();

        // Good frame: sum 00+10+03+00+AA+BB+CC = 0x244 -> 0x44
        exp_wr(16'h1000, 8'hAA); exp_wr(16'h1001, 8'hBB); exp_wr(16'h1002, 8'hCC);
        exp_res(1'b1, 2'd0, -1);
        begin_session();
        f = '{8'h00, 8'h10, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h44};
        send_frame(f);
        wait_drain(50);

        // Same frame with a wrong checksum byte
        exp_wr(16'h1000, 8'hAA); exp_wr(16'h1001, 8'hBB); exp_wr(16'h1002, 8'hCC);
        exp_res(1'b0, 2'd1, -1);
        begin_session();
        f = '{8'h00, 8'h10, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h7A};
        send_frame(f);
        wait_drain(50);

        // Address wrap: sum FF+FF+02+00+11+22 = 0x233 -> 0x33
        exp_wr(16'hFFFF, 8'h11); exp_wr(16'h0000, 8'h22);
        exp_res(1'b1, 2'd0, -1);
        begin_session();
        f = '{8'hFF, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        send_frame(f);
        wait_drain(50);

        // Zero length goes straight to checksum
        exp_res(1'b1, 2'd0, -1);
        begin_session();
        f = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h20};
        send_frame(f);
        wait_drain(50);

        // Length 0x0101 exceeds MAX_LEN 0x0100
        exp_res(1'b0, 2'd3, -1);
        begin_session();
        f = '{8'h00, 8'h40, 8'h01, 8'h01};
        send_frame(f);
        wait_drain(50);

        // Stall after addr_hi: timeout fault exactly TO cycles after the last strobe
        begin_session();
        send_byte(8'h00);
        send_byte(8'h10);
        exp_res(1'b0, 2'd2, last_strobe + TO);
        wait_drain(TO + 50);

        // Strobes outside a session must be ignored
        send_byte(8'h55);
        send_byte(8'h66);
        check("idle_hold", {31'h0, cpu_hold}, 32'h0);
        check("idle_error_kept", {30'h0, error, done}, 32'h2);

        // Reset after two payload bytes aborts the session
        exp_wr(16'h3000, 8'h01); exp_wr(16'h3001, 8'h02);
        begin_session();
        f = '{8'h00, 8'h30, 8'h04, 8'h00, 8'h01, 8'h02};
        send_frame(f);
        wait_drain(20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero_outputs("midreset_outputs");
        send_byte(8'h03);
        send_byte(8'h04);
        check("post_reset_hold", {31'h0, cpu_hold}, 32'h0);

        // A fresh session after the abort completes normally
        exp_wr(16'h1000, 8'hAA); exp_wr(16'h1001, 8'hBB); exp_wr(16'h1002, 8'hCC);
        exp_res(1'b1, 2'd0, -1);
        begin_session();
        f = '{8'h00, 8'h10, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h44};
        send_frame(f);
        wait_drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
